generador_pwm_motor: RTL and testbench
======================================

GENERADOR_PWM_MOTOR -- requirements
Module: generador_pwm_motor

Interface
REQ-001 Parameter: DIVISOR, default 195, clock cycles per PWM count tick (range 1..65535).
REQ-002 Parameter: TIEMPO_MUERTO, default 50000, dead-time length in clock cycles (range 1..2^20-1).
REQ-003 Port: CLOCK_50  input  1  system clock; all logic on its rising edge; one clock only.
REQ-004 Port: RESET  input  1  reset, synchronous and active-high.
REQ-005 Port: CICLO_UTIL  input  8  requested duty, unsigned 0..255, from the message detector PWM output.
REQ-006 Port: DIRECCION  input  2  requested direction, signed: 1 forward, -1 reverse, 0 or -2 stop.
REQ-007 Port: PWM_OUT  output  1  registered PWM enable to the H-bridge.
REQ-008 Port: MOTOR_IN1  output  1  registered bridge input 1 (forward leg).
REQ-009 Port: MOTOR_IN2  output  1  registered bridge input 2 (reverse leg).
REQ-010 Port: FIN_PERIODO  output  1  registered one-cycle pulse at each PWM period boundary.
REQ-011 Port: CAMBIANDO  output  1  registered, high while in dead time.

Function
REQ-012 Prescaler counts 0..DIVISOR-1 then wraps to 0; tick asserted on the cycle the count equals DIVISOR-1.
REQ-013 PWM counter is 8 bits, counts 0..254 and advances only on tick; wraps 254 -> 0 (period = 255 ticks = 255*DIVISOR clocks).
REQ-014 Boundary event = tick while PWM counter equals 254; FIN_PERIODO is high the cycle after each boundary event, low otherwise.
REQ-015 CICLO_UTIL and DIRECCION are sampled only at a boundary event into duty and direction latches; changes mid-period have no effect until the next boundary.
REQ-016 Raw PWM = (PWM counter < latched duty); duty 0 gives never high, duty 255 gives always high.
REQ-017 Direction FSM states: PARADO, ADELANTE, ATRAS, MUERTO.
REQ-018 PARADO: on boundary, latched direction 1 -> ADELANTE, -1 -> ATRAS, 0/-2 -> stay.
REQ-019 ADELANTE/ATRAS: on boundary, same direction -> stay; any other latched direction (opposite or stop) -> MUERTO, dead-time counter cleared to 0.
REQ-020 MUERTO: dead-time counter increments every clock; on the cycle it equals TIEMPO_MUERTO-1, go to the state given by the most recent latched direction (1 -> ADELANTE, -1 -> ATRAS, 0/-2 -> PARADO).
REQ-021 Boundary events during MUERTO update the latches but do not restart or extend the dead time.
REQ-022 Prescaler and PWM counter run continuously in all states; they are not realigned on state changes.
REQ-023 Outputs, registered one cycle after the state/counter that produces them: ADELANTE -> IN1=1, IN2=0, PWM_OUT=raw; ATRAS -> IN1=0, IN2=1, PWM_OUT=raw; PARADO/MUERTO -> IN1=0, IN2=0, PWM_OUT=0.
REQ-024 MOTOR_IN1 and MOTOR_IN2 are never high in the same cycle, and never change from one driven leg to the other without at least TIEMPO_MUERTO cycles of both low.
REQ-025 CAMBIANDO is 1 exactly while the state is MUERTO, with one cycle of delay.

Reset
REQ-026 While RESET=1 at a clock edge: prescaler, PWM counter, dead-time counter and latches go to 0, state goes to PARADO, and all outputs go to 0 on that edge.
REQ-027 Reset takes priority over every other event, including boundary and dead-time expiry; after reset the first boundary occurs 255*DIVISOR clocks after release.

Verification (DIVISOR=2, TIEMPO_MUERTO=10)
REQ-028 Hold RESET 3 cycles with random inputs -> all outputs 0 during reset and after release until the first boundary.
REQ-029 CICLO_UTIL=128, DIRECCION=1 -> after the first boundary IN1=1, IN2=0; PWM_OUT high 256 clocks, low 254 clocks per 510-clock period; FIN_PERIODO pulses every 510 clocks.
REQ-030 DIRECCION=1, duty 0, then duty 255 -> PWM_OUT constantly 0 for one full period, then constantly 1 for the following period.
REQ-031 Forward running, DIRECCION changes to -1 -> at the next boundary IN1=IN2=PWM_OUT=0 and CAMBIANDO=1 for exactly 10 cycles, then IN2=1 and PWM resumes.
REQ-032 Duty changed 128 -> 10 at mid-period -> the current period keeps 128-tick high time and the next period has 10 ticks high.
REQ-033 RESET asserted during MUERTO -> next cycle state is PARADO, CAMBIANDO=0 and both legs low; no leg drives until the first boundary after release.

Source files
------------

// File: rtl/generador_pwm_motor.sv
// PWM generator for an H-bridge motor driver: a fixed-period PWM plus a direction FSM
// that forces a dead time whenever the driven leg has to change.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// PARADO   | bridge idle, both legs and PWM low
// ADELANTE | IN1 driven, PWM enable follows the duty comparison
// ATRAS    | IN2 driven, PWM enable follows the duty comparison
// MUERTO   | dead time, both legs low until the dead-time counter expires
module generador_pwm_motor #(
  parameter int unsigned DIVISOR       = 195,
  parameter int unsigned TIEMPO_MUERTO = 50000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [7:0] CICLO_UTIL,
  input  logic [1:0] DIRECCION,
  output logic       PWM_OUT,
  output logic       MOTOR_IN1,
  output logic       MOTOR_IN2,
  output logic       FIN_PERIODO,
  output logic       CAMBIANDO
);

  localparam logic [15:0] LP_PRESC_MAX    = 16'(DIVISOR - 1);
  localparam logic [19:0] LP_MUERTO_MAX   = 20'(TIEMPO_MUERTO - 1);
  localparam logic [7:0]  LP_PWM_MAX      = 8'd254;
  localparam logic [1:0]  LP_DIR_ADELANTE = 2'b01;
  localparam logic [1:0]  LP_DIR_ATRAS    = 2'b11;

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    ADELANTE = 2'd1,
    ATRAS    = 2'd2,
    MUERTO   = 2'd3
  } estado_t;

  logic [15:0] r_presc;
  logic [7:0]  r_pwm_cnt;
  logic [7:0]  r_duty;
  logic [1:0]  r_dir;
  logic [19:0] r_muerto_cnt;
  estado_t     r_estado;
  estado_t     w_estado_sig;

  logic r_pwm_out;
  logic r_in1;
  logic r_in2;
  logic r_fin;
  logic r_camb;

  logic       w_tick;
  logic       w_frontera;
  logic       w_pwm_raw;
  logic       w_muerto_fin;
  logic [1:0] w_dir_ef;

  assign w_tick       = (r_presc == LP_PRESC_MAX);
  assign w_frontera   = w_tick && (r_pwm_cnt == LP_PWM_MAX);
  assign w_pwm_raw    = (r_pwm_cnt < r_duty);
  assign w_muerto_fin = (r_muerto_cnt == LP_MUERTO_MAX);
  // At a boundary the value being latched is already the most recent direction.
  assign w_dir_ef     = w_frontera ? DIRECCION : r_dir;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_pwm_cnt <= '0;
    end else if (w_frontera) begin
      r_pwm_cnt <= '0;
    end else if (w_tick) begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_duty <= '0;
      r_dir  <= '0;
    end else if (w_frontera) begin
      r_duty <= CICLO_UTIL;
      r_dir  <= DIRECCION;
    end
  end

  // Held at zero outside MUERTO, so every entry into dead time starts from 0.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_muerto_cnt <= '0;
    end else if (r_estado != MUERTO) begin
      r_muerto_cnt <= '0;
    end else begin
      r_muerto_cnt <= r_muerto_cnt + 20'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_estado <= PARADO;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      PARADO: begin
        if (w_frontera) begin
          if (DIRECCION == LP_DIR_ADELANTE) begin
            w_estado_sig = ADELANTE;
          end else if (DIRECCION == LP_DIR_ATRAS) begin
            w_estado_sig = ATRAS;
          end
        end
      end
      ADELANTE: begin
        if (w_frontera && (DIRECCION != LP_DIR_ADELANTE)) begin
          w_estado_sig = MUERTO;
        end
      end
      ATRAS: begin
        if (w_frontera && (DIRECCION != LP_DIR_ATRAS)) begin
          w_estado_sig = MUERTO;
        end
      end
      MUERTO: begin
        if (w_muerto_fin) begin
          if (w_dir_ef == LP_DIR_ADELANTE) begin
            w_estado_sig = ADELANTE;
          end else if (w_dir_ef == LP_DIR_ATRAS) begin
            w_estado_sig = ATRAS;
          end else begin
            w_estado_sig = PARADO;
          end
        end
      end
      default: w_estado_sig = PARADO;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_pwm_out <= 1'b0;
      r_in1     <= 1'b0;
      r_in2     <= 1'b0;
      r_fin     <= 1'b0;
      r_camb    <= 1'b0;
    end else begin
      r_pwm_out <= ((r_estado == ADELANTE) || (r_estado == ATRAS)) && w_pwm_raw;
      r_in1     <= (r_estado == ADELANTE);
      r_in2     <= (r_estado == ATRAS);
      r_fin     <= w_frontera;
      r_camb    <= (r_estado == MUERTO);
    end
  end

  assign PWM_OUT     = r_pwm_out;
  assign MOTOR_IN1   = r_in1;
  assign MOTOR_IN2   = r_in2;
  assign FIN_PERIODO = r_fin;
  assign CAMBIANDO   = r_camb;

endmodule

// File: tb/tb_generador_pwm_motor.sv
// Randomized bench for generador_pwm_motor: a time-based reference model queues the
// expected output word per clock and an independent monitor compares and checks invariants.
module tb_generador_pwm_motor;

  localparam int D = 2;
  localparam int T = 10;
  localparam int P = 255 * D;

  localparam int M_STOP = 0;
  localparam int M_FWD  = 1;
  localparam int M_REV  = 2;
  localparam int M_DEAD = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] duty_in = 8'd0;
  logic [1:0] dir_in = 2'd0;
  logic       pwm_out, in1, in2, fin, camb;

  int tests = 0;
  int fails = 0;
  bit done = 1'b0;
  int dir_val = 0;

  // Reference model: elapsed clocks since reset plus a coarse motor mode.
  int m_k = 0;
  int m_mode = M_STOP;
  int m_dead_left = 0;
  int m_duty = 0;
  int m_dir = 0;

  logic [4:0] q_esp[$];

  int ciclo = 0;
  int last_leg = 0;
  int low_run = 0;
  int gap = -1;

  always #5 clk = ~clk;

  generador_pwm_motor #(.DIVISOR(D), .TIEMPO_MUERTO(T)) dut (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .CICLO_UTIL (duty_in),
    .DIRECCION  (dir_in),
    .PWM_OUT    (pwm_out),
    .MOTOR_IN1  (in1),
    .MOTOR_IN2  (in2),
    .FIN_PERIODO(fin),
    .CAMBIANDO  (camb)
  );

  function automatic int dir_mode(input int d);
    if (d == 1) return M_FWD;
    if (d == -1) return M_REV;
    return M_STOP;
  endfunction

  task automatic report();
    if (!done) begin
      done = 1'b1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
    end
  endtask

  task automatic model_edge();
    logic [4:0] e;
    bit b;
    int cnt;
    int eff;
    if (rst) begin
      e = '0;
      m_k = 0;
      m_mode = M_STOP;
      m_dead_left = 0;
      m_duty = 0;
      m_dir = 0;
    end else begin
      b = ((m_k % P) == P - 1);
      cnt = (m_k / D) % 255;
      e = {b, m_mode == M_DEAD, m_mode == M_FWD, m_mode == M_REV,
           ((m_mode == M_FWD) || (m_mode == M_REV)) && (cnt < m_duty)};
      eff = b ? dir_val : m_dir;
      case (m_mode)
        M_STOP: if (b) m_mode = dir_mode(eff);
        M_FWD, M_REV: begin
          if (b && dir_mode(eff) != m_mode) begin
            m_mode = M_DEAD;
            m_dead_left = T;
          end
        end
        default: begin
          m_dead_left--;
          if (m_dead_left == 0) m_mode = dir_mode(eff);
        end
      endcase
      if (b) begin
        m_duty = int'(duty_in);
        m_dir = dir_val;
      end
      m_k++;
    end
    q_esp.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  task automatic set_in(input int duty, input int dir);
    duty_in = 8'(duty);
    dir_val = dir;
    dir_in = 2'(dir);
  endtask

  always @(negedge clk) begin
    logic [4:0] exp_v;
    logic [4:0] got;
    int leg;
    ciclo++;
    if (q_esp.size() > 0) begin
      exp_v = q_esp.pop_front();
      got = {fin, camb, in1, in2, pwm_out};
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL salidas ciclo=%0d {fin,camb,in1,in2,pwm} obtenido=%b esperado=%b",
                 ciclo, got, exp_v);
      end
    end
    tests++;
    if (in1 === 1'b1 && in2 === 1'b1) begin
      fails++;
      $display("FAIL piernas_simultaneas ciclo=%0d in1=%b in2=%b esperado=no ambas", ciclo, in1, in2);
    end
    if (in1 === 1'b1 || in2 === 1'b1) begin
      leg = (in1 === 1'b1) ? 1 : 2;
      if (last_leg != 0 && leg != last_leg) begin
        tests++;
        if (low_run < T) begin
          fails++;
          $display("FAIL tiempo_muerto ciclo=%0d bajo=%0d minimo=%0d", ciclo, low_run, T);
        end
      end
      last_leg = leg;
      low_run = 0;
    end else begin
      low_run++;
    end
    if (rst) begin
      gap = -1;
    end else if (fin === 1'b1) begin
      if (gap >= 0) begin
        tests++;
        if (gap + 1 != P) begin
          fails++;
          $display("FAIL periodo_fin ciclo=%0d intervalo=%0d esperado=%0d", ciclo, gap + 1, P);
        end
      end
      gap = 0;
    end else if (gap >= 0) begin
      gap++;
    end
    if (fails >= 40) begin
      report();
      $finish;
    end
  end

  initial begin
    int dirs[4];
    int guard;
    dirs = '{1, -1, 0, -2};

    // Reset with random inputs
    rst = 1'b1;
    repeat (3) begin
      set_in(int'($urandom_range(0, 255)), dirs[$urandom_range(0, 3)]);
      step(1);
    end
    rst = 1'b0;

    // Forward at half duty, then a mid-period duty change
    set_in(128, 1);
    step(2 * P + 20);
    step(255);
    set_in(10, 1);
    step(P + 40);

    // Duty extremes
    set_in(0, 1);
    step(P);
    set_in(255, 1);
    step(2 * P);

    // Reversal through dead time
    set_in(128, -1);
    step(P + 60);

    // Reset in the middle of dead time
    set_in(128, 1);
    guard = 0;
    while (camb !== 1'b1 && guard < 3 * P) begin
      step(1);
      guard++;
    end
    tests++;
    if (camb !== 1'b1) begin
      fails++;
      $display("FAIL espera_cambiando camb=%b esperado=1 tras %0d ciclos", camb, guard);
    end
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(P + 30);

    // Random traffic with occasional resets
    repeat (40) begin
      step(int'($urandom_range(5, 700)));
      set_in(int'($urandom_range(0, 255)), dirs[$urandom_range(0, 3)]);
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        step(int'($urandom_range(1, 3)));
        rst = 1'b0;
      end
    end
    step(P + 10);
    @(negedge clk);
    #1;
    report();
    $finish;
  end

endmodule
